// File: rtl/tdc_therm_decoder_if.sv
// Sample/result bundle between the TDC tap sampler and the thermometer decoder.
// The decoder takes the slave view; the sampler/consumer side takes the master view.
interface tdc_therm_decoder_if #(
   parameter int NBITS = 32,
   parameter int OUTW  = $clog2(NBITS)
);
   logic             tdc_en;
   logic [NBITS-1:0] tdc_taps;
   logic             lost_clr;
   logic [OUTW-1:0]  phase;
   logic             polarity;
   logic             phase_vld;
   logic             edge_miss;
   logic             lock_lost;
   logic [1:0]       state;

   modport master (
      output tdc_en, tdc_taps, lost_clr,
      input  phase, polarity, phase_vld, edge_miss, lock_lost, state
   );

   modport slave (
      input  tdc_en, tdc_taps, lost_clr,
      output phase, polarity, phase_vld, edge_miss, lock_lost, state
   );
endinterface

// File: rtl/tdc_therm_decoder.sv
// Three-stage TDC thermometer decoder: capture, bubble correction, first-edge search,
// with an edge-presence supervisor that flags a sticky loss of the DCO edge.
module tdc_therm_decoder #(
   parameter int NBITS      = 32,
   parameter int OUTW       = $clog2(NBITS),
   parameter int MISS_LIMIT = 4,
   parameter int MISS_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   tdc_therm_decoder_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      LOST  = 2'd2
   } state_t;

   localparam logic [MISS_W-1:0] LIMIT_C = MISS_W'(MISS_LIMIT);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [NBITS-1:0] r1_r;
   logic             v1_r;
   logic [NBITS+1:0] ext_s;
   logic [NBITS-1:0] c_s;
   logic [NBITS-1:0] c_r;
   logic             v2_r;
   logic [OUTW-1:0]  pos_s;
   logic             miss_s;
   logic [OUTW-1:0]  phase_r;
   logic             polarity_r;
   logic             phase_vld_r;
   logic             edge_miss_r;
   logic [MISS_W-1:0] cnt_r;
   logic [MISS_W-1:0] cnt_n;
   state_t           state_r;
   state_t           state_n;
   logic             lock_lost_r;
   logic             lock_lost_n;
   logic             set_s;
   logic             hit_s;
   logic             count_s;

   // Stage 1: capture the tap snapshot only when it is qualified
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_r <= '0;
         v1_r <= 1'b0;
      end else begin
         v1_r <= bus.tdc_en;
         if (bus.tdc_en) begin
            r1_r <= bus.tdc_taps;
         end
      end
   end

   // Bubble correction; the end taps are replicated so each tap sees two neighbours
   always_comb begin
      ext_s = {r1_r[NBITS-1], r1_r, r1_r[0]};
      c_s   = '0;
      for (int i = 0; i < NBITS; i++) begin
         c_s[i] = maj3(ext_s[i], ext_s[i+1], ext_s[i+2]);
      end
   end

   // Stage 2: register the corrected code
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_r  <= '0;
         v2_r <= 1'b0;
      end else begin
         c_r  <= c_s;
         v2_r <= v1_r;
      end
   end

   // First edge search; scanning downward leaves the lowest differing tap in pos_s
   always_comb begin
      pos_s  = '0;
      miss_s = 1'b1;
      for (int i = NBITS - 1; i >= 1; i--) begin
         if (c_r[i] != c_r[0]) begin
            pos_s  = OUTW'(i);
            miss_s = 1'b0;
         end else begin
            pos_s  = pos_s;
            miss_s = miss_s;
         end
      end
   end

   // Stage 3: result registers hold their value between strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_r     <= '0;
         polarity_r  <= 1'b0;
         edge_miss_r <= 1'b0;
         phase_vld_r <= 1'b0;
      end else begin
         phase_vld_r <= v2_r;
         if (v2_r) begin
            phase_r     <= pos_s;
            polarity_r  <= c_r[0];
            edge_miss_r <= miss_s;
         end
      end
   end

   assign hit_s   = phase_vld_r & ~edge_miss_r;
   assign count_s = phase_vld_r & edge_miss_r & (state_r != IDLE);

   // Supervisor next state, miss counter and sticky flag
   always_comb begin
      cnt_n       = cnt_r;
      state_n     = state_r;
      set_s       = 1'b0;
      lock_lost_n = lock_lost_r;
      if (hit_s) begin
         cnt_n = '0;
      end else if (count_s) begin
         if (cnt_r < LIMIT_C) begin
            cnt_n = cnt_r + MISS_W'(1);
         end else begin
            cnt_n = cnt_r;
         end
         set_s = (cnt_r == LIMIT_C - MISS_W'(1));
      end else begin
         cnt_n = cnt_r;
      end
      case (state_r)
         IDLE:    if (hit_s) state_n = TRACK; else state_n = IDLE;
         TRACK:   if (set_s) state_n = LOST;  else state_n = TRACK;
         LOST:    if (hit_s) state_n = TRACK; else state_n = LOST;
         default: state_n = IDLE;
      endcase
      if (set_s) begin
         lock_lost_n = 1'b1;
      end else if (bus.lost_clr) begin
         lock_lost_n = 1'b0;
      end else begin
         lock_lost_n = lock_lost_r;
      end
   end

   // Supervisor registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r       <= '0;
         state_r     <= IDLE;
         lock_lost_r <= 1'b0;
      end else begin
         cnt_r       <= cnt_n;
         state_r     <= state_n;
         lock_lost_r <= lock_lost_n;
      end
   end

   assign bus.phase     = phase_r;
   assign bus.polarity  = polarity_r;
   assign bus.phase_vld = phase_vld_r;
   assign bus.edge_miss = edge_miss_r;
   assign bus.lock_lost = lock_lost_r;
   assign bus.state     = state_r;
endmodule
